// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline sequencer: stage enables/flushes, load-use, branch redirect, dmem handshake
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNTW    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            ex_memRead,
    input  logic [4:0]      ex_wa,
    input  logic            mem_branch,
    input  logic            mem_zero,
    input  logic            mem_memRead,
    input  logic            mem_memWrite,
    input  logic            dmem_ack,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic            pc_sel,
    output logic            dmem_req,
    output logic            timeout_err,
    output logic [CNTW-1:0] stall_cnt
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   w_q, w_d;
    logic            timeout_err_q, timeout_err_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    logic acc, load_use, br_taken, mem_stall;

    always_comb begin
        acc       = mem_memRead | mem_memWrite;
        load_use  = ex_memRead && (ex_wa != 5'd0) && ((ex_wa == id_rs1) || (ex_wa == id_rs2));
        br_taken  = mem_branch & mem_zero;
        mem_stall = ((state_q == RUN) && acc && !dmem_ack) || ((state_q == MEM_WAIT) && !dmem_ack);
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        case (state_q)
            RUN: begin
                if (acc && !dmem_ack) begin
                    state_d = MEM_WAIT;
                    w_d     = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    state_d = RUN;
                    w_d     = '0;
                end else if (w_q == W_LAST) begin
                    state_d = ERR;
                end else begin
                    w_d = w_q + 1'b1;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase
    end

    // Outputs are gated by rst so they fall the instant reset is asserted.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pc_sel      = 1'b0;
        dmem_req    = rst && (((state_q == RUN) && acc) || (state_q == MEM_WAIT));
        if (rst && (state_q != ERR) && !mem_stall) begin
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (br_taken) begin
                pc_en       = 1'b1;
                ifid_en     = 1'b1;
                pc_sel      = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (load_use) begin
                idex_flush = 1'b1;
            end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
            end
        end
    end

    always_comb begin
        timeout_err_d = timeout_err_q | (state_d == ERR);
        stall_cnt_d   = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != {CNTW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            w_q           <= '0;
            timeout_err_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            w_q           <= w_d;
            timeout_err_q <= timeout_err_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign timeout_err = timeout_err_q;
    assign stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    localparam int CNTW = 8;
    // {pc_en,ifid_en,idex_en,exmem_en,memwb_en, ifid_fl,idex_fl,exmem_fl, pc_sel, dmem_req, timeout_err}
    localparam logic [10:0] ZERO   = 11'b00000_000_0_0_0;
    localparam logic [10:0] NORM   = 11'b11111_000_0_0_0;
    localparam logic [10:0] LU     = 11'b00111_010_0_0_0;
    localparam logic [10:0] BR     = 11'b11111_111_1_0_0;
    localparam logic [10:0] STALL  = 11'b00000_000_0_1_0;
    localparam logic [10:0] ACKADV = 11'b11111_000_0_1_0;
    localparam logic [10:0] ACKBR  = 11'b11111_111_1_1_0;
    localparam logic [10:0] ERRV   = 11'b00000_000_0_0_1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_wa = '0;
    logic ex_memRead = 0, mem_branch = 0, mem_zero = 0, mem_memRead = 0, mem_memWrite = 0, dmem_ack = 0;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush;
    logic pc_sel, dmem_req, timeout_err;
    logic [CNTW-1:0] stall_cnt;

    typedef struct packed {
        logic [10:0]     ctl;
        logic [CNTW-1:0] cnt;
    } exp_t;
    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(4), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_memRead(ex_memRead), .ex_wa(ex_wa),
        .mem_branch(mem_branch), .mem_zero(mem_zero),
        .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .pc_sel(pc_sel), .dmem_req(dmem_req), .timeout_err(timeout_err), .stall_cnt(stall_cnt)
    );

    function automatic logic [10:0] ctl_now();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, pc_sel, dmem_req, timeout_err};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_head(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_ctl"}, 32'(ctl_now()), 32'(e.ctl));
            chk({tag, "_cnt"}, 32'(stall_cnt), 32'(e.cnt));
        end
    endtask

    // Drive one cycle of inputs (entered just after a rising edge), check at the falling edge.
    task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic exr, input logic [4:0] wa, input logic br, input logic z,
                        input logic mr, input logic mw, input logic ack, input logic [10:0] exp_ctl);
        exp_t e;
        id_rs1 = rs1; id_rs2 = rs2; ex_memRead = exr; ex_wa = wa;
        mem_branch = br; mem_zero = z; mem_memRead = mr; mem_memWrite = mw; dmem_ack = ack;
        e.ctl = exp_ctl;
        e.cnt = CNTW'(exp_cnt);
        sb_q.push_back(e);
        @(negedge clk);
        compare_head(tag);
        @(posedge clk);
        #1;
        if (rst && !exp_ctl[10] && exp_cnt < 255) exp_cnt++;
    endtask

    task automatic idle(input string tag);
        step(tag, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, NORM);
    endtask

    initial begin
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step("in_reset", 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0, ZERO);
        rst = 1'b1;
        idle("idle");
        idle("idle2");

        step("load_use", 5'd0, 5'd5, 1, 5'd5, 0, 0, 0, 0, 0, LU);
        idle("after_lu");
        step("lu_x0", 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 0, 0, NORM);
        step("br_lu", 5'd7, 5'd3, 1, 5'd7, 1, 1, 0, 0, 0, BR);
        step("nbr_lu", 5'd7, 5'd3, 1, 5'd7, 1, 0, 0, 0, 0, LU);
        idle("after_br");

        for (int i = 0; i < 3; i++) step("mwait", 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0, STALL);
        step("mack", 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 1, ACKADV);
        idle("after_ack");
        step("zero_wait", 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 1, ACKADV);
        step("st_wait", 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, STALL);
        step("ack_br", 5'd0, 5'd0, 0, 5'd0, 1, 1, 0, 1, 1, ACKBR);
        idle("after_ackbr");

        for (int i = 0; i < 5; i++) step("to_wait", 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0, STALL);
        step("err", 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0, ERRV);
        step("err_ack", 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 1, ERRV);
        for (int i = 0; i < 250; i++) step("err_hold", 5'd0, 5'd0, 0, 5'd0, 1, 1, 0, 0, 0, ERRV);
        chk("cnt_saturated", 32'(stall_cnt), 32'd255);

        rst = 1'b0;
        exp_cnt = 0;
        #1;
        chk("err_reset_ctl", 32'(ctl_now()), 32'(ZERO));
        @(posedge clk); #1;
        rst = 1'b1;
        idle("post_err_reset");

        step("w_run", 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0, STALL);
        mem_memRead = 1'b1; dmem_ack = 1'b0;
        #2;
        chk("mid_wait_req", 32'(dmem_req), 32'd1);
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        chk("async_ctl", 32'(ctl_now()), 32'(ZERO));
        chk("async_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle("post_async");
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
